// File: rtl/simd_alu_adder_arb_if.sv
// Requester/response bundle for the shared SIMD adder arbiter.
// master = issue side and response consumer, slave = arbiter.
interface simd_alu_adder_arb_if #(
    parameter int unsigned SIMD_DATA_WIDTH            = 256,
    parameter int unsigned SIMD_ADDER_DATA_MODE_WIDTH = 2,
    parameter int unsigned NUM_REQ                    = 4,
    parameter int unsigned ID_W                       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                            req_valid;
    logic [NUM_REQ-1:0]                            req_ready;
    logic [NUM_REQ*SIMD_DATA_WIDTH-1:0]            req_a;
    logic [NUM_REQ*SIMD_DATA_WIDTH-1:0]            req_b;
    logic [NUM_REQ*SIMD_ADDER_DATA_MODE_WIDTH-1:0] req_mode;
    logic [NUM_REQ-1:0]                            req_signed;
    logic [NUM_REQ-1:0]                            req_sub;
    logic                                          rsp_valid;
    logic                                          rsp_ready;
    logic [ID_W-1:0]                               rsp_id;
    logic [SIMD_DATA_WIDTH-1:0]                    rsp_result;
    logic [SIMD_DATA_WIDTH/8-1:0]                  rsp_ovf;
    logic                                          busy;
    logic [31:0]                                   op_count;

    modport master (
        output req_valid, req_a, req_b, req_mode, req_signed, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mode, req_signed, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, busy, op_count
    );
endinterface

// File: rtl/simd_alu_adder_arb.sv
// Round-robin arbiter feeding one shared SIMD add/sub datapath through a
// two-stage (operand, result) pipeline with a backpressurable response port.
module simd_alu_adder_arb #(
    parameter int unsigned SIMD_DATA_WIDTH            = 256,
    parameter int unsigned SIMD_ADDER_DATA_MODE_WIDTH = 2,
    parameter int unsigned NUM_REQ                    = 4,
    parameter int unsigned ID_W                       = $clog2(NUM_REQ)
) (
    input logic                 clk,
    input logic                 rst,
    simd_alu_adder_arb_if.slave bus
);
    localparam int unsigned DW = SIMD_DATA_WIDTH;
    localparam int unsigned MW = SIMD_ADDER_DATA_MODE_WIDTH;
    localparam int unsigned NB = DW / 8;

    logic            s1_valid_q;
    logic [DW-1:0]   s1_a_q, s1_b_q;
    logic [MW-1:0]   s1_mode_q;
    logic            s1_signed_q, s1_sub_q;
    logic [ID_W-1:0] s1_id_q;

    logic            s2_valid_q;
    logic [DW-1:0]   s2_result_q;
    logic [NB-1:0]   s2_ovf_q;
    logic [ID_W-1:0] s2_id_q;

    logic [ID_W-1:0] rr_ptr_q;
    logic [31:0]     op_count_q;

    logic            adv1, adv2, found, accept;
    logic [ID_W-1:0] grant_id, idx;
    logic [DW-1:0]   b_eff, sum;
    logic [NB-1:0]   ovf;
    logic [8:0]      byte_sum;

    assign adv2 = !s2_valid_q || bus.rsp_ready;
    assign adv1 = !s1_valid_q || adv2;

    // First valid requester at or after rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
    end

    assign accept = !rst && found && adv1;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[grant_id] = 1'b1;
    end

    // Lane-segmented add/sub; subtraction is a + ~b + 1 per lane.
    // Overflow flags exist only for byte lanes, so other modes leave them 0.
    always_comb begin
        b_eff    = s1_sub_q ? ~s1_b_q : s1_b_q;
        sum      = '0;
        ovf      = '0;
        byte_sum = '0;
        case (s1_mode_q)
            MW'(0): begin
                for (int unsigned i = 0; i < NB; i++) begin
                    byte_sum = {1'b0, s1_a_q[i*8 +: 8]} + {1'b0, b_eff[i*8 +: 8]}
                             + 9'(s1_sub_q);
                    sum[i*8 +: 8] = byte_sum[7:0];
                    if (s1_signed_q) begin
                        ovf[i] = (s1_a_q[i*8+7] == b_eff[i*8+7])
                              && (byte_sum[7] != s1_a_q[i*8+7]);
                    end else begin
                        ovf[i] = byte_sum[8] ^ s1_sub_q;
                    end
                end
            end
            MW'(1): begin
                for (int unsigned i = 0; i < DW / 16; i++) begin
                    sum[i*16 +: 16] = s1_a_q[i*16 +: 16] + b_eff[i*16 +: 16] + 16'(s1_sub_q);
                end
            end
            MW'(2): begin
                for (int unsigned i = 0; i < DW / 32; i++) begin
                    sum[i*32 +: 32] = s1_a_q[i*32 +: 32] + b_eff[i*32 +: 32] + 32'(s1_sub_q);
                end
            end
            default: begin
                for (int unsigned i = 0; i < DW / 64; i++) begin
                    sum[i*64 +: 64] = s1_a_q[i*64 +: 64] + b_eff[i*64 +: 64] + 64'(s1_sub_q);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= '0;
            s1_signed_q <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_id_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_ovf_q    <= '0;
            s2_id_q     <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_q <= sum;
                    s2_ovf_q    <= ovf;
                    s2_id_q     <= s1_id_q;
                end
            end
            if (adv1) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_a_q      <= bus.req_a[32'(grant_id)*DW +: DW];
                    s1_b_q      <= bus.req_b[32'(grant_id)*DW +: DW];
                    s1_mode_q   <= bus.req_mode[32'(grant_id)*MW +: MW];
                    s1_signed_q <= bus.req_signed[grant_id];
                    s1_sub_q    <= bus.req_sub[grant_id];
                    s1_id_q     <= grant_id;
                end
            end
            if (accept) begin
                rr_ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
            if (s2_valid_q && bus.rsp_ready) op_count_q <= op_count_q + 32'd1;
        end
    end

    assign bus.rsp_valid  = s2_valid_q;
    assign bus.rsp_id     = s2_id_q;
    assign bus.rsp_result = s2_result_q;
    assign bus.rsp_ovf    = s2_ovf_q;
    assign bus.busy       = s1_valid_q || s2_valid_q;
    assign bus.op_count   = op_count_q;
endmodule
